psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the 8-bit/dual-4-bit multiplier.
- Consumes one PSUM_WIDTH product per beat and accumulates it into a running partial sum.
- The accumulation honours the multiplier mode: one full-width sum in 8-bit mode, or two independent half-width lane sums in 4-bit mode.
- Emits one result per group (group ends on in_last) over a valid/ready handshake to the PE output path.

Parameters:
- PSUM_WIDTH, 32, product/sum width (diff_demo_pkg value); even, >= 24.
- CNT_WIDTH, 8, width of the per-group beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_mode  input  1  0: 8-bit full-width; 1: two 4-bit lanes (upper/lower half).
- in_psum  input  PSUM_WIDTH  product from multiplier.
- in_last  input  1  final beat of current group.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_psum  output  PSUM_WIDTH  accumulated sum.
- out_mode  output  1  mode of the group.
- out_ovf  output  2  sticky carry-out; bit1 = upper lane, bit0 = lower lane or full width.
- out_cnt  output  CNT_WIDTH  beats in group, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_psum=0, out_mode=0, out_ovf=0, out_cnt=0.
  - Accumulator, internal mode, internal ovf and internal count all 0.
  - FSM goes to IDLE.
  - Reset mid-group discards the partial sum; no output is produced for that group.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). Input stalls only while a result is held and not taken.
  - Result transferred when out_valid && out_ready.
- FSM:
  - IDLE: accepted beat latches in_mode as the group mode, loads acc=in_psum, cnt=1, ovf=0.
    - If in_last: go to IDLE and emit the result. Otherwise go to ACC.
  - ACC: accepted beat adds to acc using the latched group mode (in_mode ignored until the next group), cnt += 1 saturating at 2^CNT_WIDTH-1.
    - If in_last: emit the result and return to IDLE.
- Arithmetic:
  - Mode 0: acc = acc + in_psum mod 2^PSUM_WIDTH; carry-out sets sticky ovf[0]; ovf[1]=0.
  - Mode 1: each PSUM_WIDTH/2 half adds independently mod 2^(PSUM_WIDTH/2), with no carry between halves; per-lane carry sets ovf[1]/ovf[0].
  - All values unsigned.
- Emit:
  - Beat with in_last accepted at edge t ⇒ at t+1, out_valid=1 and out_psum/out_mode/out_ovf/out_cnt hold the group result including that beat.
  - The accumulator clears in the same edge.
- Hold: out_* stay stable while out_valid && !out_ready.
- out_valid drops the cycle after the transfer, unless a new last beat is accepted at the same edge; then the outputs are replaced by the new result (back-to-back groups, 1 result per cycle).
- A new group may start the cycle after a last beat, with no bubble.
- in_valid=0 cycles inside a group leave the accumulator unchanged.

Test Plan:
- Mode 0 group, beats 100, 200, 300 (last on 300), out_ready=1 ⇒ one cycle after the last beat: out_psum=600, out_cnt=3, out_ovf=0, out_mode=0; out_valid high for exactly 1 cycle.
- Mode 1 lane wrap: beats 0x8000_FFFF, then 0x8000_0002 (last) ⇒ out_psum=0x0000_0001, out_ovf=2'b11, with no carry from the lower half into the upper half. Same beats in mode 0 ⇒ out_psum=0x0001_0001, out_ovf=2'b01.
- Backpressure:
  - Hold out_ready=0 after a single-beat group (in_psum=5, in_last=1) ⇒ out_valid stays 1, out_psum stays 5, in_ready=0.
  - Raise out_ready while a second single-beat group (7, last) is waiting ⇒ 5 is transferred, and 7 appears the next cycle with no lost or duplicated result.
- Mode change mid-group: first beat mode 1, second beat (last) driven with in_mode=0 ⇒ lane-wise add applied, out_mode=1.
- Reset mid-group: beats 10, 20 (no last), rst_n low 1 cycle, then 3 (last) ⇒ out_psum=3, out_cnt=1. While rst_n=0, all outputs are 0.
- Counter saturation (CNT_WIDTH=8): 300 beats of value 1, last on the 300th ⇒ out_psum=300, out_cnt=255.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates multiplier products per group (full-width or dual-lane) and emits one result per group over valid/ready.
module psum_accumulator #(
    parameter int PSUM_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [PSUM_WIDTH-1:0] in_psum,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_psum,
    output logic                  out_mode,
    output logic [1:0]            out_ovf,
    output logic [CNT_WIDTH-1:0]  out_cnt
);
    localparam int H = PSUM_WIDTH / 2;
    typedef enum logic {IDLE, ACC} state_t;
    state_t                state;
    logic [PSUM_WIDTH-1:0] acc, base, nsum;
    logic [PSUM_WIDTH:0]   full;
    logic [H:0]            lo, hi;
    logic                  mode, nmode, beat, first;
    logic [1:0]            ovf, bovf, novf;
    logic [CNT_WIDTH-1:0]  cnt, ncnt;
    assign in_ready = !(out_valid && !out_ready);
    assign beat     = in_valid && in_ready;
    assign first    = state == IDLE;
    // The first beat of a group behaves like an add onto a cleared accumulator.
    always_comb begin
        nmode = first ? in_mode : mode;
        base  = first ? '0 : acc;
        bovf  = first ? 2'b00 : ovf;
        full  = {1'b0, base} + {1'b0, in_psum};
        lo    = {1'b0, base[H-1:0]} + {1'b0, in_psum[H-1:0]};
        hi    = {1'b0, base[PSUM_WIDTH-1:H]} + {1'b0, in_psum[PSUM_WIDTH-1:H]};
        nsum  = nmode ? {hi[H-1:0], lo[H-1:0]} : full[PSUM_WIDTH-1:0];
        novf  = nmode ? (bovf | {hi[H], lo[H]}) : (bovf | {1'b0, full[PSUM_WIDTH]});
        ncnt  = first ? CNT_WIDTH'(1) : (&cnt ? cnt : cnt + 1'b1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mode      <= 1'b0;
            ovf       <= 2'b00;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_psum  <= '0;
            out_mode  <= 1'b0;
            out_ovf   <= 2'b00;
            out_cnt   <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (beat && in_last) begin
                out_valid <= 1'b1;
                out_psum  <= nsum;
                out_mode  <= nmode;
                out_ovf   <= novf;
                out_cnt   <= ncnt;
                state     <= IDLE;
                acc       <= '0;
                mode      <= 1'b0;
                ovf       <= 2'b00;
                cnt       <= '0;
            end else if (beat) begin
                state <= ACC;
                acc   <= nsum;
                mode  <= nmode;
                ovf   <= novf;
                cnt   <= ncnt;
            end
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed scenarios plus randomized traffic checked against a lane-arithmetic reference model.
module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_mode, in_last, out_valid, out_ready, out_mode;
    logic [31:0] in_psum, out_psum;
    logic [1:0]  out_ovf;
    logic [7:0]  out_cnt;
    int          errors = 0, checks = 0;

    typedef struct packed {
        logic [31:0] p;
        logic        m;
        logic [1:0]  o;
        logic [7:0]  c;
    } res_t;
    res_t q[$];

    psum_accumulator #(.PSUM_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_psum(in_psum), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_psum(out_psum), .out_mode(out_mode), .out_ovf(out_ovf), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic m, input logic [31:0] p, input logic l);
        in_valid = v;
        in_mode  = m;
        in_psum  = p;
        in_last  = l;
    endtask

    function automatic logic [43:0] obs();
        return {out_valid, out_psum, out_mode, out_ovf, out_cnt};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 44'd0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_sum;
        drive(1'b1, 1'b0, 32'd100, 1'b0); @(negedge clk);
        drive(1'b1, 1'b0, 32'd200, 1'b0); @(negedge clk);
        drive(1'b1, 1'b0, 32'd300, 1'b1); @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 32'd600, 1'b0, 2'b00, 8'd3}) begin
            errors++;
            $display("FAIL mode0_sum got=%h exp=%h", obs(), {1'b1, 32'd600, 1'b0, 2'b00, 8'd3});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mode0_valid_pulse got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_lane_wrap;
        for (int m = 1; m >= 0; m--) begin
            drive(1'b1, m[0], 32'h8000_FFFF, 1'b0); @(negedge clk);
            drive(1'b1, m[0], 32'h8000_0002, 1'b1); @(negedge clk);
            drive(1'b0, 1'b0, 32'd0, 1'b0);
            checks++;
            if (m == 1 && obs() !== {1'b1, 32'h0000_0001, 1'b1, 2'b11, 8'd2}) begin
                errors++;
                $display("FAIL lane_wrap_mode1 got=%h exp=%h", obs(), {1'b1, 32'h0000_0001, 1'b1, 2'b11, 8'd2});
            end
            if (m == 0 && obs() !== {1'b1, 32'h0001_0001, 1'b0, 2'b01, 8'd2}) begin
                errors++;
                $display("FAIL lane_wrap_mode0 got=%h exp=%h", obs(), {1'b1, 32'h0001_0001, 1'b0, 2'b01, 8'd2});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'd5, 1'b1); @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_valid, out_psum, in_ready} !== {1'b1, 32'd5, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold got=%h exp=%h", {out_valid, out_psum, in_ready}, {1'b1, 32'd5, 1'b0});
            end
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 32'd7, 1'b1); @(negedge clk);
        checks++;
        if ({out_valid, out_psum} !== {1'b1, 32'd5}) begin
            errors++;
            $display("FAIL bp_stalled_input got=%h exp=%h", {out_valid, out_psum}, {1'b1, 32'd5});
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release got=%b exp=1", in_ready);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 32'd7, 1'b0, 2'b00, 8'd1}) begin
            errors++;
            $display("FAIL bp_second_result got=%h exp=%h", obs(), {1'b1, 32'd7, 1'b0, 2'b00, 8'd1});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_duplicate got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_mode_change;
        drive(1'b1, 1'b1, 32'h0001_FFFF, 1'b0); @(negedge clk);
        drive(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0); @(negedge clk);
        drive(1'b1, 1'b0, 32'h0001_0001, 1'b1); @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 32'h0002_0000, 1'b1, 2'b01, 8'd2}) begin
            errors++;
            $display("FAIL mode_change got=%h exp=%h", obs(), {1'b1, 32'h0002_0000, 1'b1, 2'b01, 8'd2});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_group;
        drive(1'b1, 1'b0, 32'd10, 1'b0); @(negedge clk);
        drive(1'b1, 1'b0, 32'd20, 1'b0); @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 44'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h exp=%h", obs(), 44'd0);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'd3, 1'b1); @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 32'd3, 1'b0, 2'b00, 8'd1}) begin
            errors++;
            $display("FAIL reset_mid_result got=%h exp=%h", obs(), {1'b1, 32'd3, 1'b0, 2'b00, 8'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 1'b0, 32'd1, i == 300);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 32'd300, 1'b0, 2'b00, 8'd255}) begin
            errors++;
            $display("FAIL cnt_saturation got=%h exp=%h", obs(), {1'b1, 32'd300, 1'b0, 2'b00, 8'd255});
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        bit     in_grp = 0, gm = 0;
        longint tot = 0, lo = 0, hi = 0;
        int     n = 0, drain = 0;
        res_t   e;
        q.delete();
        for (int cyc = 0; cyc < 2000 && (cyc < 1500 || in_grp || q.size() != 0); cyc++) begin
            if (cyc < 1500) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0);
                out_ready = $urandom_range(0, 2) != 0;
            end else begin
                drive(in_grp, 1'b0, $urandom, 1'b1);
                out_ready = 1'b1;
                drain++;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected_result got=%h exp=none", obs());
                end else begin
                    e = q.pop_front();
                    if ({out_psum, out_mode, out_ovf, out_cnt} !== e) begin
                        errors++;
                        $display("FAIL rand_result got=%h exp=%h", {out_psum, out_mode, out_ovf, out_cnt}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (!in_grp) begin
                    gm = in_mode; tot = 0; lo = 0; hi = 0; n = 0; in_grp = 1;
                end
                tot += longint'(in_psum);
                lo  += longint'(in_psum[15:0]);
                hi  += longint'(in_psum[31:16]);
                n++;
                if (in_last) begin
                    e.p = gm ? {hi[15:0], lo[15:0]} : tot[31:0];
                    e.m = gm;
                    e.o = gm ? {hi >= 65536, lo >= 65536} : {1'b0, tot >= 64'h1_0000_0000};
                    e.c = n > 255 ? 8'd255 : 8'(n);
                    q.push_back(e);
                    in_grp = 0;
                end
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (q.size() != 0 || in_grp || drain >= 500) begin
            errors++;
            $display("FAIL rand_drain got=%0d pending exp=0", q.size());
        end
    endtask

    initial begin
        test_reset;
        test_mode0_sum;
        test_lane_wrap;
        test_backpressure;
        test_mode_change;
        test_reset_mid_group;
        test_saturation;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
